johnson_decoder: RTL and testbench
==================================

# johnson_decoder

Receive-side companion to the team's Johnson counter. Samples a WIDTH-bit Johnson-coded word, decodes it to a binary index (and optionally one-hot), flags illegal codes, and runs a lock state machine that checks each sample is the legal successor of the previous one. It sits downstream of any Johnson-coded state source (counter, ring-coded bus, CDC-crossed phase word) and provides lock status and an error count to monitoring logic.

## Interface
- WIDTH, 4, Johnson word width; sequence length is 2*WIDTH states; legal range 2..16.
- LOCK_LEN, 3, consecutive legal successor steps required to declare lock; legal range 1..15.
- IW (localparam), $clog2(2*WIDTH), index width.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- jc_valid  input  1  qualifies jc this cycle.
- jc  input  WIDTH  Johnson-coded sample.
- err_clr  input  1  synchronous clear of err_cnt.
- idx  output  IW  decoded index of last legal sample.
- onehot  output  2*WIDTH  one-hot of idx (see Configuration).
- idx_valid  output  1  one-cycle pulse: idx updated.
- illegal  output  1  one-cycle pulse: accepted sample was not a Johnson code.
- seq_err  output  1  one-cycle pulse: lock lost.
- locked  output  1  level: state is LOCKED.
- err_cnt  output  8  saturating count of seq_err events.

## Operation
- Code mapping (source shifts right, inverted LSB fed to MSB): index k < WIDTH -> k ones from MSB, rest zero; index k >= WIDTH -> (k-WIDTH) zeros from MSB, rest ones. WIDTH=4: 0000=0, 1000=1, 1100=2, 1110=3, 1111=4, 0111=5, 0011=6, 0001=7.
- Any other pattern is illegal (e.g. 1010, 0100).
- Successor of index k is (k+1) mod 2*WIDTH; 7 -> 0 wrap is legal.
- Repeat (same index as previous legal sample) is a hold: no error, no progress.
- Samples with jc_valid=0 are ignored; no state or output changes except pulses returning to 0.
- States: SEARCH, ACQUIRE, LOCKED; reset state SEARCH; internal step count cnt.
- SEARCH: legal -> ACQUIRE, cnt=1; illegal -> stay, pulse illegal.
- ACQUIRE: successor -> cnt+1, LOCKED when cnt+1 == LOCK_LEN; hold -> no change; legal non-successor -> cnt=1, stay; illegal -> SEARCH, pulse illegal.
- LOCKED: successor or hold -> stay; legal non-successor -> ACQUIRE, cnt=1, pulse seq_err; illegal -> SEARCH, pulse illegal and seq_err.
- LOCK_LEN=1: first legal sample in SEARCH goes directly to LOCKED.
- idx/onehot updated on every legal accepted sample in any state; held otherwise.
- err_cnt increments on each seq_err, saturates at 255; err_clr forces 0 and wins over a simultaneous increment.

## Timing
- All outputs registered; one cycle latency from sampled jc to idx, idx_valid, illegal, seq_err, locked.
- Reset values: idx=0, onehot=0, idx_valid=0, illegal=0, seq_err=0, locked=0, err_cnt=0, state SEARCH, cnt=0.
- Reset assertion mid-stream clears everything asynchronously; first sample after deassertion is treated as in SEARCH.
- Back-to-back valid samples every cycle supported; no backpressure.
- Pulses last exactly one cycle per offending sample.

## Configuration
- JDEC_ONEHOT_EN defined: onehot = 1 << idx, registered alongside idx, reset 0.
- Undefined: one-hot register and decode logic omitted; onehot port remains and is driven constant 0.

## Test plan
- WIDTH=4, LOCK_LEN=3: reset, feed 0000,1000,1100 valid every cycle -> idx 0,1,2; locked rises 1 cycle after the 1100 sample; no errors.
- Locked, feed 1110,1111,0111,0011,0001,0000 -> idx 3..7,0; locked stays 1 across wrap; err_cnt=0.
- Locked at idx 2, feed 1010 -> illegal=1 and seq_err=1 one cycle later, locked=0, idx stays 2, err_cnt=1.
- Locked at idx 1, feed 1110 (skip) -> seq_err pulse, state ACQUIRE, idx=3; then 1111,0111 -> relock.
- Drive 256+ seq_err events -> err_cnt holds 255; err_clr with a simultaneous seq_err -> err_cnt=0.
- Mid-stream reset_n low while locked -> all outputs 0 immediately; hold samples (repeat 1100 with gaps in jc_valid) never raise seq_err.

Source files
------------

// File: rtl/johnson_decoder.sv
// Johnson-code receiver: decodes a WIDTH-bit Johnson word to an index, flags illegal
// codes and tracks successor lock. Optional one-hot output enabled by JDEC_ONEHOT_EN.
module johnson_decoder #(
    parameter int WIDTH    = 4,
    parameter int LOCK_LEN = 3,
    localparam int IW      = $clog2(2 * WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 jc_valid,
    input  logic [WIDTH-1:0]     jc,
    input  logic                 err_clr,
    output logic [IW-1:0]        idx,
    output logic [2*WIDTH-1:0]   onehot,
    output logic                 idx_valid,
    output logic                 illegal,
    output logic                 seq_err,
    output logic                 locked,
    output logic [7:0]           err_cnt
);

    localparam int NS = 2 * WIDTH;
    localparam logic [IW-1:0] LAST_IDX   = IW'(NS - 1);
    localparam logic [3:0]    LOCK_LEN_C = 4'(LOCK_LEN);
    localparam logic          DIRECT_LOCK = (LOCK_LEN <= 1);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t            state_r, state_next_s;
    logic [3:0]        cnt_r, cnt_next_s, cnt_inc_s;
    logic [IW-1:0]     idx_r, dec_idx_s, succ_idx_s;
    logic [NS-1:0]     match_s;
    logic              dec_legal_s, accept_s, is_succ_s, is_hold_s;
    logic              illegal_s, seq_err_s;
    logic              idx_valid_r, illegal_r, seq_err_r, locked_r;
    logic [7:0]        err_cnt_r;

    // Code for index k: k<WIDTH -> k ones from MSB; otherwise (k-WIDTH) zeros from MSB.
    function automatic logic [WIDTH-1:0] jc_code(input int k);
        logic [WIDTH-1:0] ones;
        ones = {WIDTH{1'b1}};
        if (k < WIDTH) begin
            jc_code = ~(ones >> k);
        end else begin
            jc_code = ones >> (k - WIDTH);
        end
    endfunction

    // Match the sample against every legal code; at most one entry can hit.
    always_comb begin
        match_s   = '0;
        dec_idx_s = '0;
        for (int k = 0; k < NS; k++) begin
            match_s[k] = (jc == jc_code(k));
            dec_idx_s  = dec_idx_s | (match_s[k] ? IW'(k) : '0);
        end
        dec_legal_s = |match_s;
    end

    // Successor/hold relative to the last legal sample held in idx_r.
    always_comb begin
        succ_idx_s = (idx_r == LAST_IDX) ? '0 : idx_r + IW'(1);
        is_succ_s  = (dec_idx_s == succ_idx_s);
        is_hold_s  = (dec_idx_s == idx_r);
        accept_s   = jc_valid & dec_legal_s;
        cnt_inc_s  = cnt_r + 4'd1;
    end

    // Lock state machine next-state and pulse generation.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        illegal_s    = 1'b0;
        seq_err_s    = 1'b0;
        if (jc_valid) begin
            case (state_r)
                SEARCH: begin
                    if (dec_legal_s) begin
                        cnt_next_s   = 4'd1;
                        state_next_s = DIRECT_LOCK ? LOCKED : ACQUIRE;
                    end else begin
                        illegal_s = 1'b1;
                    end
                end
                ACQUIRE: begin
                    if (!dec_legal_s) begin
                        illegal_s    = 1'b1;
                        state_next_s = SEARCH;
                        cnt_next_s   = 4'd0;
                    end else if (is_succ_s) begin
                        cnt_next_s   = cnt_inc_s;
                        state_next_s = (cnt_inc_s >= LOCK_LEN_C) ? LOCKED : ACQUIRE;
                    end else if (is_hold_s) begin
                        cnt_next_s = cnt_r;
                    end else begin
                        cnt_next_s = 4'd1;
                    end
                end
                LOCKED: begin
                    if (!dec_legal_s) begin
                        illegal_s    = 1'b1;
                        seq_err_s    = 1'b1;
                        state_next_s = SEARCH;
                        cnt_next_s   = 4'd0;
                    end else if (is_succ_s || is_hold_s) begin
                        state_next_s = LOCKED;
                    end else begin
                        seq_err_s    = 1'b1;
                        state_next_s = ACQUIRE;
                        cnt_next_s   = 4'd1;
                    end
                end
                default: begin
                    state_next_s = SEARCH;
                    cnt_next_s   = 4'd0;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // State, index and pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= SEARCH;
            cnt_r       <= 4'd0;
            idx_r       <= '0;
            idx_valid_r <= 1'b0;
            illegal_r   <= 1'b0;
            seq_err_r   <= 1'b0;
            locked_r    <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            idx_valid_r <= accept_s;
            illegal_r   <= illegal_s;
            seq_err_r   <= seq_err_s;
            locked_r    <= (state_next_s == LOCKED);
            if (accept_s) begin
                idx_r <= dec_idx_s;
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    // Saturating error counter; a clear beats a coincident increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_r <= 8'd0;
        end else if (err_clr) begin
            err_cnt_r <= 8'd0;
        end else if (seq_err_s && (err_cnt_r != 8'd255)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

`ifdef JDEC_ONEHOT_EN
    logic [NS-1:0] onehot_r;
    localparam logic [NS-1:0] OH_LSB = NS'(1);

    // One-hot image of idx, updated with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            onehot_r <= '0;
        end else if (accept_s) begin
            onehot_r <= OH_LSB << dec_idx_s;
        end else begin
            onehot_r <= onehot_r;
        end
    end

    assign onehot = onehot_r;
`else
    assign onehot = '0;
`endif

    assign idx       = idx_r;
    assign idx_valid = idx_valid_r;
    assign illegal   = illegal_r;
    assign seq_err   = seq_err_r;
    assign locked    = locked_r;
    assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_johnson_decoder.sv
// Randomized and directed bench for johnson_decoder against a behavioural model.
module tb_johnson_decoder;

    localparam int W  = 4;
    localparam int LL = 3;
    localparam int NS = 2 * W;
    localparam int IW = $clog2(NS);

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              jc_valid = 1'b0;
    logic [W-1:0]      jc = '0;
    logic              err_clr = 1'b0;
    logic [IW-1:0]     idx;
    logic [NS-1:0]     onehot;
    logic              idx_valid, illegal, seq_err, locked;
    logic [7:0]        err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: mode 0 searching, 1 acquiring, 2 locked
    int m_mode, m_run, m_idx, m_err;
    int m_iv, m_ill, m_seq;

    johnson_decoder #(.WIDTH(W), .LOCK_LEN(LL)) dut (
        .clk(clk), .reset_n(reset_n), .jc_valid(jc_valid), .jc(jc), .err_clr(err_clr),
        .idx(idx), .onehot(onehot), .idx_valid(idx_valid), .illegal(illegal),
        .seq_err(seq_err), .locked(locked), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int code_of(input int k);
        if (k < W) return ((1 << k) - 1) << (W - k);
        return (1 << (NS - k)) - 1;
    endfunction

    // Index from population count, legality by re-encoding.
    function automatic bit ref_decode(input int word, output int k);
        int c;
        c = $countones(word);
        k = ((word >> (W - 1)) & 1) == 1 || word == 0 ? c : NS - c;
        return (k < NS) && (code_of(k) == word);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_run = 0; m_idx = 0; m_err = 0;
        m_iv = 0; m_ill = 0; m_seq = 0;
    endtask

    task automatic model_step(input bit v, input int word, input bit clr);
        int k;
        bit ok, succ, hold;
        m_iv = 0; m_ill = 0; m_seq = 0;
        if (v) begin
            ok = ref_decode(word, k);
            if (!ok) begin
                m_ill = 1;
                if (m_mode == 2) m_seq = 1;
                m_mode = 0;
            end else begin
                succ = (k == (m_idx + 1) % NS);
                hold = (k == m_idx);
                if (m_mode == 0) begin
                    m_run = 1;
                    m_mode = (LL <= 1) ? 2 : 1;
                end else if (m_mode == 1) begin
                    if (succ) begin
                        m_run++;
                        if (m_run >= LL) m_mode = 2;
                    end else if (!hold) m_run = 1;
                end else if (!succ && !hold) begin
                    m_seq = 1; m_mode = 1; m_run = 1;
                end
                m_idx = k;
                m_iv = 1;
            end
        end
        if (clr) m_err = 0;
        else if (m_seq == 1 && m_err < 255) m_err++;
    endtask

    task automatic check_all();
        check("idx", int'(idx), m_idx);
        check("idx_valid", int'(idx_valid), m_iv);
        check("illegal", int'(illegal), m_ill);
        check("seq_err", int'(seq_err), m_seq);
        check("locked", int'(locked), (m_mode == 2) ? 1 : 0);
        check("err_cnt", int'(err_cnt), m_err);
`ifdef JDEC_ONEHOT_EN
        check("onehot", int'(onehot), 1 << m_idx);
`else
        check("onehot", int'(onehot), 0);
`endif
    endtask

    task automatic drive(input bit v, input int word, input bit clr);
        @(negedge clk);
        jc_valid = v;
        jc       = W'(word);
        err_clr  = clr;
        @(posedge clk);
        model_step(v, word, clr);
        #1;
        check_all();
    endtask

    task automatic drive_idx(input int k);
        drive(1'b1, code_of(k), 1'b0);
    endtask

    initial begin
        int r, word;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        check("rst_locked", int'(locked), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Acquire lock from 0000,1000,1100
        drive(1'b1, 4'b0000, 1'b0); check("acq_idx0", int'(idx), 0);
        drive(1'b1, 4'b1000, 1'b0); check("acq_idx1", int'(idx), 1);
        check("acq_not_locked", int'(locked), 0);
        drive(1'b1, 4'b1100, 1'b0); check("acq_idx2", int'(idx), 2);
        check("lock_rise", int'(locked), 1);

        // Walk through the wrap while locked
        for (int k = 3; k <= 8; k++) begin
            drive_idx(k % NS);
            check("wrap_idx", int'(idx), k % NS);
            check("wrap_locked", int'(locked), 1);
        end
        check("wrap_err", int'(err_cnt), 0);

        // Illegal code while locked at 2
        drive_idx(1); drive_idx(2);
        drive(1'b1, 4'b1010, 1'b0);
        check("ill_pulse", int'(illegal), 1);
        check("ill_seq", int'(seq_err), 1);
        check("ill_unlock", int'(locked), 0);
        check("ill_idx_held", int'(idx), 2);
        check("ill_err", int'(err_cnt), 1);
        drive(1'b0, 4'b1010, 1'b0);
        check("pulse_clear", int'(illegal), 0);

        // Skip while locked at 1, then relock
        drive_idx(6); drive_idx(7); drive_idx(0); drive_idx(1);
        check("pre_skip_lock", int'(locked), 1);
        drive(1'b1, 4'b1110, 1'b0);
        check("skip_seq", int'(seq_err), 1);
        check("skip_idx", int'(idx), 3);
        check("skip_unlock", int'(locked), 0);
        drive(1'b1, 4'b1111, 1'b0);
        drive(1'b1, 4'b0111, 1'b0);
        check("relock", int'(locked), 1);

        // Saturate err_cnt
        drive(1'b1, 4'b0100, 1'b0);
        for (int i = 0; i < 300; i++) begin
            drive_idx(0); drive_idx(1); drive_idx(2);
            drive(1'b1, 4'b1010, 1'b0);
        end
        check("sat_255", int'(err_cnt), 255);
        drive_idx(0); drive_idx(1); drive_idx(2);
        drive(1'b1, 4'b1010, 1'b1);
        check("clr_seq", int'(seq_err), 1);
        check("clr_wins", int'(err_cnt), 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 10)      drive(1'b0, $urandom_range(0, NS * 2 - 1), 1'b0);
            else if (r < 25) drive_idx(m_idx);
            else if (r < 75) drive_idx((m_idx + 1) % NS);
            else if (r < 85) drive_idx($urandom_range(0, NS - 1));
            else begin
                word = $urandom_range(0, (1 << W) - 1);
                drive(1'b1, word, ($urandom_range(0, 29) == 0));
            end
        end

        // Async reset while locked, then holds with gaps
        drive_idx(0); drive_idx(1); drive_idx(2); drive_idx(3);
        check("pre_rst_lock", int'(locked), 1);
        @(negedge clk);
        jc_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, 4'b1100, 1'b0);
        check("post_rst_idx", int'(idx), 2);
        for (int i = 0; i < 12; i++) begin
            drive((i % 3) != 1, 4'b1100, 1'b0);
            check("hold_no_seq", int'(seq_err), 0);
        end
        check("hold_no_lock", int'(locked), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
